// File: rtl/axi_lite_ram_dual.sv
// axi_lite_ram_dual: AXI4-Lite slave RAM with independent, concurrent read and write channels.
// Optional macro AXI_RAM_PROT_EN: writes with AWPROT[0]=0 are refused with SLVERR.
module axi_lite_ram_dual #(
  parameter int unsigned NUM_SLOTS        = 16,
  parameter int unsigned DATA_WIDTH_BYTES = 4,
  parameter int unsigned ADDR_WIDTH       = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          ARVALID,
  output logic                          ARREADY,
  input  logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic [2:0]                    ARPROT,
  output logic                          RVALID,
  input  logic                          RREADY,
  output logic [DATA_WIDTH_BYTES*8-1:0] RDATA,
  output logic [1:0]                    RRESP,
  input  logic                          AWVALID,
  output logic                          AWREADY,
  input  logic [ADDR_WIDTH-1:0]         AWADDR,
  input  logic [2:0]                    AWPROT,
  input  logic                          WVALID,
  output logic                          WREADY,
  input  logic [DATA_WIDTH_BYTES*8-1:0] WDATA,
  input  logic [DATA_WIDTH_BYTES-1:0]   WSTRB,
  output logic                          BVALID,
  input  logic                          BREADY,
  output logic [1:0]                    BRESP
);

  localparam int unsigned DW       = DATA_WIDTH_BYTES * 8;
  localparam int unsigned WORD_LSB = $clog2(DATA_WIDTH_BYTES);
  localparam int unsigned IDX_W    = ADDR_WIDTH - WORD_LSB;
  localparam int unsigned SLOT_W   = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [1:0] RESP_OKAY   = 2'd0;
  localparam logic [1:0] RESP_SLVERR = 2'd2;
  localparam logic [1:0] RESP_DECERR = 2'd3;

  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_RESP} r_state_e;
  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} w_state_e;

  logic [DW-1:0] r_mem [NUM_SLOTS];

  // Holds all readys low until the first edge after reset release.
  logic r_rdy_en;

  r_state_e             r_rstate;
  r_state_e             w_rstate_next;
  logic                 r_ar_held;
  logic [IDX_W-1:0]     r_ar_idx;
  logic [DW-1:0]        r_rdata;
  logic [1:0]           r_rresp;
  logic                 w_ar_hs;
  logic                 w_rd_in_range;
  logic [SLOT_W-1:0]    w_rd_slot;

  w_state_e             r_wstate;
  w_state_e             w_wstate_next;
  logic                 r_aw_held;
  logic [IDX_W-1:0]     r_aw_idx;
  logic                 r_w_held;
  logic [DW-1:0]        r_wdata;
  logic [DATA_WIDTH_BYTES-1:0] r_wstrb;
  logic [1:0]           r_bresp;
  logic                 w_aw_hs;
  logic                 w_w_hs;
  logic                 w_wr_in_range;
  logic                 w_wr_denied;
  logic                 w_wr_en;
  logic [1:0]           w_commit_resp;
  logic [SLOT_W-1:0]    w_wr_slot;

  logic                 w_unused;
  assign w_unused = ^{ARPROT, AWPROT, ARADDR, AWADDR};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdy_en <= 1'b0;
    end else begin
      r_rdy_en <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- read channel
  assign w_ar_hs       = ARVALID && ARREADY;
  assign w_rd_in_range = (32'(r_ar_idx) < NUM_SLOTS);
  assign w_rd_slot     = r_ar_idx[SLOT_W-1:0];

  always_comb begin
    w_rstate_next = r_rstate;
    ARREADY       = 1'b0;
    RVALID        = 1'b0;
    unique case (r_rstate)
      R_IDLE: begin
        ARREADY = r_rdy_en && !r_ar_held;
        if (r_ar_held) w_rstate_next = R_ACCESS;
      end
      R_ACCESS: w_rstate_next = R_RESP;
      R_RESP: begin
        RVALID = 1'b1;
        if (RREADY) w_rstate_next = R_IDLE;
      end
      default: w_rstate_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rstate  <= R_IDLE;
      r_ar_held <= 1'b0;
      r_ar_idx  <= '0;
      r_rdata   <= '0;
      r_rresp   <= RESP_OKAY;
    end else begin
      r_rstate <= w_rstate_next;
      if (w_ar_hs) begin
        r_ar_held <= 1'b1;
        r_ar_idx  <= ARADDR[ADDR_WIDTH-1:WORD_LSB];
      end else if (r_rstate == R_IDLE && r_ar_held) begin
        r_ar_held <= 1'b0;
      end
      // Samples the array on the same edge a commit writes it, so collisions read old data.
      if (r_rstate == R_ACCESS) begin
        r_rdata <= w_rd_in_range ? r_mem[w_rd_slot] : '0;
        r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_DECERR;
      end
    end
  end

  assign RDATA = r_rdata;
  assign RRESP = r_rresp;

  // --------------------------------------------------------------- write channel
  assign w_aw_hs       = AWVALID && AWREADY;
  assign w_w_hs        = WVALID && WREADY;
  assign w_wr_in_range = (32'(r_aw_idx) < NUM_SLOTS);
  assign w_wr_slot     = r_aw_idx[SLOT_W-1:0];

`ifdef AXI_RAM_PROT_EN
  logic r_aw_priv;
  assign w_wr_denied = !r_aw_priv;
`else
  assign w_wr_denied = 1'b0;
`endif

  assign w_commit_resp = !w_wr_in_range ? RESP_DECERR :
                         w_wr_denied    ? RESP_SLVERR : RESP_OKAY;
  assign w_wr_en       = (r_wstate == W_COMMIT) && w_wr_in_range && !w_wr_denied;

  always_comb begin
    w_wstate_next = r_wstate;
    AWREADY       = 1'b0;
    WREADY        = 1'b0;
    BVALID        = 1'b0;
    unique case (r_wstate)
      W_IDLE: begin
        AWREADY = r_rdy_en && !r_aw_held;
        WREADY  = r_rdy_en && !r_w_held;
        if (r_aw_held && r_w_held) w_wstate_next = W_COMMIT;
      end
      W_COMMIT: w_wstate_next = W_RESP;
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_wstate_next = W_IDLE;
      end
      default: w_wstate_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wstate  <= W_IDLE;
      r_aw_held <= 1'b0;
      r_aw_idx  <= '0;
      r_w_held  <= 1'b0;
      r_wdata   <= '0;
      r_wstrb   <= '0;
      r_bresp   <= RESP_OKAY;
`ifdef AXI_RAM_PROT_EN
      r_aw_priv <= 1'b0;
`endif
    end else begin
      r_wstate <= w_wstate_next;
      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_aw_idx  <= AWADDR[ADDR_WIDTH-1:WORD_LSB];
`ifdef AXI_RAM_PROT_EN
        r_aw_priv <= AWPROT[0];
`endif
      end else if (r_wstate == W_COMMIT) begin
        r_aw_held <= 1'b0;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= WDATA;
        r_wstrb  <= WSTRB;
      end else if (r_wstate == W_COMMIT) begin
        r_w_held <= 1'b0;
      end
      if (r_wstate == W_COMMIT) r_bresp <= w_commit_resp;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      for (int b = 0; b < int'(DATA_WIDTH_BYTES); b++) begin
        if (r_wstrb[b]) r_mem[w_wr_slot][8*b +: 8] <= r_wdata[8*b +: 8];
      end
    end
  end

  assign BRESP = r_bresp;

endmodule

// File: tb/tb_axi_lite_ram_dual.sv
// Scoreboard bench for axi_lite_ram_dual: directed scenarios plus randomized traffic
// checked against an array model; honours AXI_RAM_PROT_EN when defined.
module tb_axi_lite_ram_dual;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [7:0]  ARADDR = '0;
  logic [2:0]  ARPROT = '0;
  logic        RVALID;
  logic        RREADY = 1'b0;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [7:0]  AWADDR = '0;
  logic [2:0]  AWPROT = '0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        BVALID;
  logic        BREADY = 1'b0;
  logic [1:0]  BRESP;

  axi_lite_ram_dual #(
    .NUM_SLOTS(16),
    .DATA_WIDTH_BYTES(4),
    .ADDR_WIDTH(8)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
    .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
    .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
    .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [33:0] rq[$];   // {rresp, rdata}
  logic [1:0]  bq[$];
  logic [31:0] mdl [16];
  int rmode = 0;        // 0 always ready, 1 random, 2 held low
  int bmode = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: got timeout expected completion", name);
  endtask

  function automatic logic [33:0] model_read(input logic [7:0] a);
    if (a[7:2] < 6'd16) return {2'b00, mdl[a[5:2]]};
    return {2'b11, 32'h0};
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                             input logic [3:0] s, input logic [2:0] p);
    if (a[7:2] >= 6'd16) return 2'b11;
`ifdef AXI_RAM_PROT_EN
    if (!p[0]) return 2'b10;
`else
    if (p[0] === 1'bx) return 2'b00;
`endif
    for (int b = 0; b < 4; b++) if (s[b]) mdl[a[5:2]][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  task automatic ar_send(input logic [7:0] a, input bit push);
    int n = 0;
    @(posedge clk); #1;
    ARADDR = a;
    ARVALID = 1'b1;
    do begin @(negedge clk); n++; end while (!ARREADY && n < 100);
    if (!ARREADY) begin
      timeout("ar_handshake");
      ARVALID = 1'b0;
      return;
    end
    @(posedge clk); #1;
    ARVALID = 1'b0;
    if (push) rq.push_back(model_read(a));
  endtask

  task automatic wr_send(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                         input logic [2:0] p, input int aw_dly, input int w_dly);
    bit aw_done = 0, w_done = 0, aw_fire, w_fire;
    int t = 0;
    @(posedge clk); #1;
    AWADDR = a; AWPROT = p; WDATA = d; WSTRB = s;
    while (!(aw_done && w_done) && t < 200) begin
      AWVALID = !aw_done && t >= aw_dly;
      WVALID  = !w_done && t >= w_dly;
      @(negedge clk);
      aw_fire = AWVALID && AWREADY;
      w_fire  = WVALID && WREADY;
      @(posedge clk); #1;
      if (aw_fire) aw_done = 1;
      if (w_fire) w_done = 1;
      t++;
    end
    AWVALID = 1'b0;
    WVALID = 1'b0;
    if (!(aw_done && w_done)) timeout("aw_w_handshake");
    else bq.push_back(model_write(a, d, s, p));
  endtask

  task automatic lat_chk(input string name, input bit is_b);
    int k = 0;
    bit seen = 0;
    while (!seen && k < 10) begin
      @(negedge clk);
      k++;
      seen = is_b ? BVALID : RVALID;
    end
    chk(name, 64'(k), 64'd3);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((rq.size() != 0 || bq.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (rq.size() != 0 || bq.size() != 0) begin
      timeout("response_drain");
      rq.delete();
      bq.delete();
    end
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      RREADY = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
      BREADY = (bmode == 0) ? 1'b1 : (bmode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each completed response and checks stall stability.
  bit          r_stall = 0, b_stall = 0;
  logic [33:0] r_hold;
  logic [1:0]  b_hold;
  always @(negedge clk) begin
    if (!rst_n) begin
      r_stall = 0;
      b_stall = 0;
    end else begin
      if (r_stall) chk("r_stable", {29'd0, RVALID, RRESP, RDATA}, {29'd0, 1'b1, r_hold});
      if (b_stall) chk("b_stable", {61'd0, BVALID, BRESP}, {61'd0, 1'b1, b_hold});
      if (RVALID && RREADY) begin
        chk("r_expected", 64'(rq.size() > 0), 64'd1);
        if (rq.size() > 0) chk("r_data_resp", 64'({RRESP, RDATA}), 64'(rq.pop_front()));
      end
      if (BVALID && BREADY) begin
        chk("b_expected", 64'(bq.size() > 0), 64'd1);
        if (bq.size() > 0) chk("b_resp", 64'(BRESP), 64'(bq.pop_front()));
      end
      r_stall = RVALID && !RREADY;
      r_hold  = {RRESP, RDATA};
      b_stall = BVALID && !BREADY;
      b_hold  = BRESP;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {ARREADY, RVALID, RDATA, RRESP, AWREADY, WREADY, BVALID, BRESP}, '0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", {ARREADY, AWREADY, WREADY}, 3'b000);
    @(posedge clk); #1;
    chk("ready_after_edge", {ARREADY, AWREADY, WREADY}, 3'b111);

    for (int i = 0; i < 16; i++) wr_send(8'(i * 4), $urandom, 4'hF, 3'b001, 0, 0);
    wait_idle();

    // Full write then read back, with latency on both channels.
    wr_send(8'h04, 32'h11223344, 4'hF, 3'b001, 0, 0);
    lat_chk("b_latency", 1);
    wait_idle();
    ar_send(8'h04, 1);
    lat_chk("r_latency", 0);
    wait_idle();

    // W three cycles ahead of AW, single byte lane.
    wr_send(8'h04, 32'hAABBCCDD, 4'h2, 3'b001, 3, 0);
    wait_idle();
    ar_send(8'h04, 1);
    wait_idle();
    chk("strb_merge", 64'(mdl[1]), 64'h1122CC44);

    // Out-of-range read and write, word 0 untouched.
    ar_send(8'h40, 1);
    wait_idle();
    wr_send(8'h40, 32'hFFFFFFFF, 4'hF, 3'b001, 1, 0);
    wait_idle();
    ar_send(8'h00, 1);
    wait_idle();

    // Back-pressure on both response channels.
    rmode = 2;
    bmode = 2;
    ar_send(8'h04, 1);
    wr_send(8'h08, 32'h0BADF00D, 4'hF, 3'b001, 0, 2);
    n = 0;
    while (!(RVALID && BVALID) && n < 20) begin @(negedge clk); n++; end
    if (!(RVALID && BVALID)) timeout("stall_setup");
    repeat (5) begin
      @(negedge clk);
      chk("ready_during_stall", {ARREADY, AWREADY, WREADY}, 3'b000);
    end
    rmode = 0;
    bmode = 0;
    wait_idle();

    // Read and commit hit the same word in the same cycle: read sees the old value.
    wr_send(8'h08, 32'h5, 4'hF, 3'b001, 0, 0);
    wait_idle();
    rq.push_back({2'b00, 32'h5});
    fork
      ar_send(8'h08, 0);
      wr_send(8'h08, 32'h9, 4'hF, 3'b001, 0, 0);
    join
    wait_idle();
    ar_send(8'h08, 1);
    wait_idle();

    // Reset while a read response is pending.
    rmode = 2;
    ar_send(8'h0C, 1);
    n = 0;
    while (!RVALID && n < 20) begin @(negedge clk); n++; end
    if (!RVALID) timeout("rvalid_before_reset");
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("reset_drops_rvalid", {RVALID, ARREADY, RDATA}, '0);
    rq.delete();
    bq.delete();
    rmode = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("arready_after_reset", {ARREADY, AWREADY, WREADY}, 3'b111);

    // Unprivileged write: refused only when protection is compiled in.
    wr_send(8'h0C, 32'hDEADBEEF, 4'hF, 3'b000, 0, 0);
    wait_idle();
    ar_send(8'h0C, 1);
    wait_idle();

    rmode = 1;
    bmode = 1;
    for (int i = 0; i < 150; i++) begin
      logic [7:0] a;
      a = 8'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) begin
        ar_send(a, 1);
      end else begin
        wr_send(a, $urandom, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
                $urandom_range(0, 3), $urandom_range(0, 3));
      end
      wait_idle();
    end
    rmode = 0;
    bmode = 0;
    for (int i = 0; i < 16; i++) begin
      ar_send(8'(i * 4), 1);
      wait_idle();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
